// File: rtl/cp_insert_sched_if.sv
// Sample-stream bundle for the cyclic-prefix insertion scheduler.
// The slave modport is the scheduler's view: it consumes the s_* stream
// and produces the m_* stream. The master modport is the view of the
// surrounding datapath (IFFT on the input side, framer on the output side).
interface cp_insert_sched_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_cp;
  logic              m_last;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_cp, m_last
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_cp, m_last
  );
endinterface

// File: rtl/cp_insert_sched.sv
// Cyclic-prefix insertion scheduler.
// Buffers each incoming time-domain symbol in one bank of a ping-pong
// memory and replays it with its last CP samples prepended. The writer
// fills one bank while the reader FSM (IDLE/CP/BODY) drains the other.
// Reads are registered; a two-entry skid stage behind the RAM read keeps
// the output stream lossless under downstream backpressure.
// Optional feature: define CP_SYM_COUNT_EN to build the 16-bit completed
// symbol counter on sym_count; otherwise sym_count is tied to zero.
module cp_insert_sched #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          cfg_log2_n,
  input  logic [MAX_LOG2:0]   cfg_cp_len,
  cp_insert_sched_if.slave    bus,
  output logic                cfg_err,
  output logic [15:0]         sym_count
);

  localparam int unsigned AW    = MAX_LOG2;
  localparam int unsigned DEPTH = 1 << AW;

  typedef logic [AW:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_BODY
  } rd_state_t;

  function automatic len_t pow2(input logic [2:0] l2);
    pow2 = len_t'(1) << l2;
  endfunction

  // Ping-pong sample memory, bank select in the top address bit
  logic [DATA_W-1:0] mem [2*DEPTH];

  // Per-bank latched configuration and occupancy
  logic [2:0]  bank_log2 [2];
  len_t        bank_cp   [2];
  logic [1:0]  full;

  // Writer state
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          wr_fire;
  logic          wr_first;
  logic          wr_end;
  len_t          wr_n;

  // Configuration sanitising
  logic [2:0] clamp_log2;
  len_t       clamp_n;
  len_t       clamp_cp;
  logic       log2_bad;
  logic       cp_bad;

  // Reader state
  rd_state_t state;
  logic      rd_bank;
  len_t      rd_addr;
  len_t      rd_n;
  len_t      rd_cp_len;
  len_t      iss_addr;
  logic      phase_cp;
  logic      at_end;
  logic      iss_last;
  logic      issue;
  logic      issue_ok;
  logic      rd_done;
  logic      nb;
  len_t      nb_n;
  len_t      nb_cp_len;

  // Registered RAM read and its sideband
  logic [DATA_W-1:0] rd_q;
  logic              rd_v;
  logic              rd_cp;
  logic              rd_last;

  // Two-entry skid stage
  logic [DATA_W-1:0] sk_data [2];
  logic [1:0]        sk_cp;
  logic [1:0]        sk_last;
  logic              sk_wp;
  logic              sk_rp;
  logic [1:0]        sk_cnt;
  logic [1:0]        occ;
  logic              sk_push;
  logic              sk_pop;

  // Output view
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_cp;
  logic              out_last;

  // Clamp the live configuration into the legal range and flag violations
  always_comb begin
    log2_bad = (cfg_log2_n < 3'd2) || (cfg_log2_n > 3'(MAX_LOG2));
    if (cfg_log2_n < 3'd2) begin
      clamp_log2 = 3'd2;
    end else if (cfg_log2_n > 3'(MAX_LOG2)) begin
      clamp_log2 = 3'(MAX_LOG2);
    end else begin
      clamp_log2 = cfg_log2_n;
    end
    clamp_n  = pow2(clamp_log2);
    cp_bad   = cfg_cp_len > clamp_n;
    clamp_cp = cp_bad ? clamp_n : cfg_cp_len;
  end

  assign bus.s_ready = ~full[wr_bank];
  assign wr_fire     = bus.s_valid && ~full[wr_bank];
  assign wr_first    = (wr_addr == '0);

  // The first sample of a bank still sees the live config; later ones the latched copy
  always_comb begin
    wr_n   = wr_first ? clamp_n : pow2(bank_log2[wr_bank]);
    wr_end = ({1'b0, wr_addr} == wr_n - len_t'(1));
  end

  // Store accepted samples into the current write bank
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_addr}] <= bus.s_data;
    end
  end

  // Writer sequencing: address, bank toggle, config latch and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
      cfg_err <= 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
        bank_log2[b] <= 3'd2;
        bank_cp[b]   <= '0;
      end
    end else if (wr_fire) begin
      if (wr_first) begin
        bank_log2[wr_bank] <= clamp_log2;
        bank_cp[wr_bank]   <= clamp_cp;
        if (log2_bad || cp_bad) begin
          cfg_err <= 1'b1;
        end
      end
      if (wr_end) begin
        wr_addr <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  // Bank full flags: set by the writer on its last sample, cleared by the reader
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
    end else begin
      if (wr_fire && wr_end) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // Issue only while the skid stage can still absorb one more in-flight read
  assign occ      = sk_cnt + {1'b0, rd_v};
  assign issue_ok = (occ <= 2'd1);

  // Current read address and phase; IDLE issues the first address directly
  always_comb begin
    rd_n      = pow2(bank_log2[rd_bank]);
    rd_cp_len = bank_cp[rd_bank];
    phase_cp  = (state == ST_CP) || ((state == ST_IDLE) && (rd_cp_len != '0));
    if (state == ST_IDLE) begin
      iss_addr = (rd_cp_len != '0) ? rd_n - rd_cp_len : '0;
    end else begin
      iss_addr = rd_addr;
    end
    issue     = ((state != ST_IDLE) || full[rd_bank]) && issue_ok;
    at_end    = (iss_addr == rd_n - len_t'(1));
    iss_last  = !phase_cp && at_end;
    nb        = ~rd_bank;
    nb_n      = pow2(bank_log2[nb]);
    nb_cp_len = bank_cp[nb];
  end

  assign rd_done = issue && iss_last;

  // Reader FSM: prefix then body, chaining straight into the next full bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
    end else if (issue) begin
      if (phase_cp) begin
        if (at_end) begin
          state   <= ST_BODY;
          rd_addr <= '0;
        end else begin
          state   <= ST_CP;
          rd_addr <= iss_addr + len_t'(1);
        end
      end else if (at_end) begin
        rd_bank <= nb;
        if (full[nb]) begin
          if (nb_cp_len != '0) begin
            state   <= ST_CP;
            rd_addr <= nb_n - nb_cp_len;
          end else begin
            state   <= ST_BODY;
            rd_addr <= '0;
          end
        end else begin
          state   <= ST_IDLE;
          rd_addr <= '0;
        end
      end else begin
        state   <= ST_BODY;
        rd_addr <= iss_addr + len_t'(1);
      end
    end
  end

  // Registered RAM read with prefix/last sideband
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      rd_v    <= 1'b0;
      rd_cp   <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_v <= issue;
      if (issue) begin
        rd_q    <= mem[{rd_bank, iss_addr[AW-1:0]}];
        rd_cp   <= phase_cp;
        rd_last <= iss_last;
      end
    end
  end

  // Read data bypasses the skid stage when it is empty and downstream is ready
  assign sk_push = rd_v && !((sk_cnt == 2'd0) && bus.m_ready);
  assign sk_pop  = (sk_cnt != 2'd0) && bus.m_ready;

  // Skid stage holding reads that downstream has not yet taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sk_wp   <= 1'b0;
      sk_rp   <= 1'b0;
      sk_cnt  <= 2'd0;
      sk_cp   <= '0;
      sk_last <= '0;
      for (int unsigned e = 0; e < 2; e++) begin
        sk_data[e] <= '0;
      end
    end else begin
      if (sk_push) begin
        sk_data[sk_wp] <= rd_q;
        sk_cp[sk_wp]   <= rd_cp;
        sk_last[sk_wp] <= rd_last;
        sk_wp          <= ~sk_wp;
      end
      if (sk_pop) begin
        sk_rp <= ~sk_rp;
      end
      case ({sk_push, sk_pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end

  // Present the skid head if occupied, otherwise the fresh RAM read
  always_comb begin
    if (sk_cnt != 2'd0) begin
      out_data  = sk_data[sk_rp];
      out_cp    = sk_cp[sk_rp];
      out_last  = sk_last[sk_rp];
      out_valid = 1'b1;
    end else begin
      out_data  = rd_q;
      out_cp    = rd_v & rd_cp;
      out_last  = rd_v & rd_last;
      out_valid = rd_v;
    end
  end

  assign bus.m_data  = out_data;
  assign bus.m_valid = out_valid;
  assign bus.m_cp    = out_cp;
  assign bus.m_last  = out_last;

`ifdef CP_SYM_COUNT_EN
  // Count completed extended symbols, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_count <= '0;
    end else if (out_valid && bus.m_ready && out_last) begin
      sym_count <= sym_count + 16'd1;
    end
  end
`else
  assign sym_count = '0;
`endif

endmodule

// File: tb/tb_cp_insert_sched.sv
// Directed testbench for cp_insert_sched: streams symbols in, collects the
// output stream at the falling edge and compares it to hand-derived
// prefix/body sequences.
module tb_cp_insert_sched;

  localparam int unsigned DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cfg_log2_n;
  logic [6:0]  cfg_cp_len;
  logic        cfg_err;
  logic [15:0] sym_count;

  logic        m_ready_q = 1'b1;
  logic        bp_mode   = 1'b0;
  int unsigned bp_ph     = 0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned stalls   = 0;
  int unsigned last_acc = 0;

  logic [DATA_W-1:0] q_data [$];
  logic              q_cp   [$];
  logic              q_last [$];
  int unsigned       q_cyc  [$];

  logic              hold_arm = 1'b0;
  logic [DATA_W+2:0] hold_val;

  cp_insert_sched_if #(.DATA_W(DATA_W)) bus ();

  cp_insert_sched #(.DATA_W(DATA_W), .MAX_LOG2(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_log2_n (cfg_log2_n),
    .cfg_cp_len (cfg_cp_len),
    .bus        (bus),
    .cfg_err    (cfg_err),
    .sym_count  (sym_count)
  );

  assign bus.m_ready = m_ready_q;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always 1, or the repeating 1,0,0,1 pattern
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      m_ready_q = (bp_ph == 0) || (bp_ph == 3);
      bp_ph     = (bp_ph + 1) % 4;
    end else begin
      m_ready_q = 1'b1;
      bp_ph     = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output collector plus hold check while downstream stalls
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (hold_arm) begin
        check("hold", {bus.m_valid, bus.m_cp, bus.m_last, bus.m_data}, hold_val);
      end
      if (bus.m_valid && bus.m_ready) begin
        q_data.push_back(bus.m_data);
        q_cp.push_back(bus.m_cp);
        q_last.push_back(bus.m_last);
        q_cyc.push_back(cyc);
      end
      hold_arm = bus.m_valid && !bus.m_ready;
      hold_val = {bus.m_valid, bus.m_cp, bus.m_last, bus.m_data};
    end else begin
      hold_arm = 1'b0;
    end
  end

  task automatic clear_q();
    q_data.delete();
    q_cp.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(negedge clk);
    clear_q();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned base, input int unsigned n, input bit scramble);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned t;
      t           = 0;
      bus.s_data  = DATA_W'(base + i);
      bus.s_valid = 1'b1;
      @(negedge clk);
      while (!bus.s_ready && t < 200) begin
        stalls++;
        t++;
        @(negedge clk);
      end
      if (t >= 200) begin
        check("s_ready_timeout", 64'd0, 64'd1);
        break;
      end
      last_acc = cyc;
      @(posedge clk);
      #1;
      if (scramble && i == 0) begin
        cfg_log2_n = 3'd7;
        cfg_cp_len = 7'd70;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int unsigned n);
    int unsigned t;
    t = 0;
    while (q_data.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
    check({tag, "_count"}, 64'(q_data.size()), 64'(n));
    @(posedge clk);
    #1;
  endtask

  // Expected extended symbol: base+N-CP..base+N-1 flagged cp, then base..base+N-1
  task automatic expect_sym(input string tag, input int unsigned idx0,
                            input int unsigned base, input int unsigned n,
                            input int unsigned cp);
    for (int unsigned k = 0; k < n + cp; k++) begin
      logic [63:0] e;
      logic [63:0] g;
      int unsigned d;
      d = (k < cp) ? base + n - cp + k : base + k - cp;
      e = {30'd0, (k < cp), (k == n + cp - 1), 32'(d)};
      if (idx0 + k < q_data.size()) begin
        g = {30'd0, q_cp[idx0+k], q_last[idx0+k], q_data[idx0+k]};
      end else begin
        g = '1;
      end
      check($sformatf("%s[%0d]", tag, k), g, e);
    end
  endtask

  function automatic int unsigned span(input int unsigned n);
    return (q_cyc.size() >= n) ? q_cyc[n-1] - q_cyc[0] : 0;
  endfunction

  function automatic int unsigned first_lat();
    return (q_cyc.size() > 0) ? q_cyc[0] - last_acc : 0;
  endfunction

  initial begin
    int unsigned exp_sym;
    rst         = 1'b0;
    cfg_log2_n  = 3'd3;
    cfg_cp_len  = 7'd2;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_s_ready",   64'(bus.s_ready), 64'd1);
    check("rst_m_valid",   64'(bus.m_valid), 64'd0);
    check("rst_m_cp",      64'(bus.m_cp),    64'd0);
    check("rst_m_last",    64'(bus.m_last),  64'd0);
    check("rst_m_data",    64'(bus.m_data),  64'd0);
    check("rst_cfg_err",   64'(cfg_err),     64'd0);
    check("rst_sym_count", 64'(sym_count),   64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic N=8 CP=2; config is corrupted after the first sample and must be ignored
    send(0, 8, 1'b1);
    wait_out("basic", 10);
    expect_sym("basic", 0, 0, 8, 2);
    check("basic_latency", 64'(first_lat()), 64'd2);
    check("basic_span",    64'(span(10)),     64'd9);
    check("basic_cfg_err", 64'(cfg_err),      64'd0);
`ifdef CP_SYM_COUNT_EN
    exp_sym = 1;
`else
    exp_sym = 0;
`endif
    check("basic_sym_count", 64'(sym_count), 64'(exp_sym));

    // Back-to-back: N=16 CP=4, three symbols streamed continuously
    do_reset();
    cfg_log2_n = 3'd4;
    cfg_cp_len = 7'd4;
    stalls     = 0;
    send(0, 16, 1'b0);
    send(16, 16, 1'b0);
    send(32, 16, 1'b0);
    wait_out("b2b", 60);
    expect_sym("b2b0", 0, 0, 16, 4);
    expect_sym("b2b1", 20, 16, 16, 4);
    expect_sym("b2b2", 40, 32, 16, 4);
    check("b2b_span",   64'(span(60)), 64'd59);
    check("b2b_stalls", 64'(stalls),   64'd4);
`ifdef CP_SYM_COUNT_EN
    exp_sym = 3;
`else
    exp_sym = 0;
`endif
    check("b2b_sym_count", 64'(sym_count), 64'(exp_sym));

    // Backpressure: m_ready 1,0,0,1 repeating
    do_reset();
    cfg_log2_n = 3'd3;
    cfg_cp_len = 7'd2;
    bp_mode    = 1'b1;
    send(0, 8, 1'b0);
    wait_out("bp", 10);
    expect_sym("bp", 0, 0, 8, 2);
    bp_mode = 1'b0;

    // CP=0 passthrough
    do_reset();
    cfg_log2_n = 3'd3;
    cfg_cp_len = 7'd0;
    send(100, 8, 1'b0);
    wait_out("cp0", 8);
    expect_sym("cp0", 0, 100, 8, 0);

    // CP=N
    do_reset();
    cfg_log2_n = 3'd3;
    cfg_cp_len = 7'd8;
    send(0, 8, 1'b0);
    wait_out("cp8", 16);
    expect_sym("cp8", 0, 0, 8, 8);

    // Config errors: N clamps to 64, CP clamps to 64
    do_reset();
    cfg_log2_n = 3'd7;
    cfg_cp_len = 7'd70;
    send(0, 64, 1'b0);
    wait_out("err", 128);
    expect_sym("err", 0, 0, 64, 64);
    check("err_cfg_err", 64'(cfg_err), 64'd1);
    clear_q();
    cfg_log2_n = 3'd3;
    cfg_cp_len = 7'd2;
    send(200, 8, 1'b0);
    wait_out("err_after", 10);
    expect_sym("err_after", 0, 200, 8, 2);
    check("err_sticky", 64'(cfg_err), 64'd1);

    // Reset after 5 of 8 samples discards the partial symbol
    do_reset();
    cfg_log2_n = 3'd3;
    cfg_cp_len = 7'd2;
    send(0, 5, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rmid_m_valid", 64'(bus.m_valid), 64'd0);
    check("rmid_s_ready", 64'(bus.s_ready), 64'd1);
    check("rmid_m_data",  64'(bus.m_data),  64'd0);
    clear_q();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(10, 8, 1'b0);
    wait_out("rmid", 10);
    expect_sym("rmid", 0, 10, 8, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
